// File: rtl/renas_ahb_peri_slave_if.sv
// AHB-lite bus bundle between the matrix peripheral port and renas_ahb_peri_slave.
// master : drives the address/control, write data and bus-level hready; sees the response.
// slave  : samples the address/control, write data and hready; returns
//          hrdata/hreadyout/hresp.
interface renas_ahb_peri_slave_if #(
  parameter int ADDR_W = 12
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic [31:0]       hrdata;
  logic              hreadyout;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/renas_ahb_peri_slave.sv
// AHB-lite responder for the peripheral slave port of the AHB matrix.
// Decodes transfers into NUM_REGS 32-bit registers. Every OKAY data phase gets
// WAIT_STATES wait cycles. Illegal transfers get a two-cycle ERROR response.
// The register bank is exported flat to the peripheral logic.
// Ports:
//   hclk_i    bus clock
//   hreset_i  asynchronous, active-high reset
//   bus       AHB-lite slave modport (hsel/haddr/htrans/hwrite/hsize/hwdata/hready in,
//             hrdata/hreadyout/hresp out)
//   regs_o    register k at [32k+31:32k]
module renas_ahb_peri_slave #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 12
) (
  input  logic                     hclk_i,
  input  logic                     hreset_i,
  renas_ahb_peri_slave_if.slave    bus,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam int              IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] WIN_END = (ADDR_W + 1)'(NUM_REGS * 4);
  localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_write_q, pend_write_d;
  logic [1:0]       pend_size_q, pend_size_d;
  logic [1:0]       pend_lo_q, pend_lo_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];

  logic             ready;
  logic             accept;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             commit;
  logic             unused_ok;

  // Merge write data into the old word on the byte lanes picked by size and addr[1:0].
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [3:0]  be;
    logic [31:0] res;
    case (size)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // The slave drives hreadyout high only in IDLE and ERR2.
  // Those are the only cycles in which a new address phase may be taken.
  assign ready   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept  = bus.hsel & bus.hready & bus.htrans[1] & ready;
  assign acc_idx = bus.haddr[IDX_W+1:2];
  assign acc_err = ({1'b0, bus.haddr} >= WIN_END) ||
                   (bus.hsize > 3'd2) ||
                   ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                   ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));

  // A pending write commits at the edge that ends its final (IDLE) data cycle.
  assign commit    = (state_q == ST_IDLE) && pend_vld_q && pend_write_q;
  assign unused_ok = bus.htrans[0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_vld_d   = pend_vld_q;
    pend_write_d = pend_write_q;
    pend_size_d  = pend_size_q;
    pend_lo_d    = pend_lo_q;
    pend_idx_d   = pend_idx_q;
    hrdata_d     = hrdata_q;
    regs_d       = regs_q;

    if (commit) begin
      regs_d[pend_idx_q] = merge_lanes(regs_q[pend_idx_q], bus.hwdata, pend_size_q, pend_lo_q);
    end

    // hrdata reads from regs_d, so a read that starts on the commit edge sees the merged value.
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d    = ST_IDLE;
        pend_vld_d = 1'b0;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            pend_vld_d   = 1'b1;
            pend_write_d = bus.hwrite;
            pend_size_d  = bus.hsize[1:0];
            pend_lo_d    = bus.haddr[1:0];
            pend_idx_d   = acc_idx;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WS_LOAD;
            end else if (!bus.hwrite) begin
              hrdata_d = regs_d[acc_idx];
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (!pend_write_q) hrdata_d = regs_d[pend_idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_ERR2;
    endcase
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      pend_vld_q   <= 1'b0;
      pend_write_q <= 1'b0;
      pend_size_q  <= 2'd0;
      pend_lo_q    <= 2'd0;
      pend_idx_q   <= '0;
      hrdata_q     <= 32'd0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_vld_q   <= pend_vld_d;
      pend_write_q <= pend_write_d;
      pend_size_q  <= pend_size_d;
      pend_lo_q    <= pend_lo_d;
      pend_idx_q   <= pend_idx_d;
      hrdata_q     <= hrdata_d;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = ready;
  assign bus.hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_renas_ahb_peri_slave.sv
module tb_renas_ahb_peri_slave;

  logic         clk;
  logic         hreset;
  logic         nrdy_a;
  logic [511:0] regs_a;
  logic [511:0] regs_b;
  int           nvec;
  int           nmis;

  renas_ahb_peri_slave_if #(.ADDR_W(12)) ifa ();
  renas_ahb_peri_slave_if #(.ADDR_W(12)) ifb ();

  // Single slave on each bus: bus-level hready follows the slave, with an override for testing.
  assign ifa.hready = nrdy_a ? 1'b0 : ifa.hreadyout;
  assign ifb.hready = ifb.hreadyout;

  renas_ahb_peri_slave #(.NUM_REGS(16), .WAIT_STATES(1), .ADDR_W(12)) u_ws1 (
    .hclk_i   (clk),
    .hreset_i (hreset),
    .bus      (ifa),
    .regs_o   (regs_a)
  );

  renas_ahb_peri_slave #(.NUM_REGS(16), .WAIT_STATES(0), .ADDR_W(12)) u_ws0 (
    .hclk_i   (clk),
    .hreset_i (hreset),
    .bus      (ifb),
    .regs_o   (regs_b)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_a(input logic sel, input logic [1:0] trans, input logic [11:0] addr,
                        input logic wr, input logic [2:0] size);
    ifa.hsel   = sel;
    ifa.htrans = trans;
    ifa.haddr  = addr;
    ifa.hwrite = wr;
    ifa.hsize  = size;
  endtask

  task automatic addr_b(input logic sel, input logic [1:0] trans, input logic [11:0] addr,
                        input logic wr, input logic [2:0] size);
    ifb.hsel   = sel;
    ifb.htrans = trans;
    ifb.haddr  = addr;
    ifb.hwrite = wr;
    ifb.hsize  = size;
  endtask

  initial begin
    clk = 1'b0;
    hreset = 1'b1;
    nrdy_a = 1'b0;
    nvec = 0;
    nmis = 0;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    addr_b(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    ifa.hwdata = 32'd0;
    ifb.hwdata = 32'd0;
    cyc();
    cyc();
    hreset = 1'b0;

    // Reset state
    chk("rst_hreadyout", {31'd0, ifa.hreadyout}, 32'd1);
    chk("rst_hresp", {31'd0, ifa.hresp}, 32'd0);
    chk("rst_hrdata", ifa.hrdata, 32'd0);
    chk("rst_regs_or", {31'd0, |regs_a}, 32'd0);

    // WAIT_STATES=1: word write 0xDEADBEEF @0x08
    addr_a(1'b1, 2'b10, 12'h008, 1'b1, 3'd2);
    cyc();
    chk("wr08_wait_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("wr08_wait_resp", {31'd0, ifa.hresp}, 32'd0);
    ifa.hwdata = 32'hDEADBEEF;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("wr08_final_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    // pipelined read @0x08 during the write's final cycle
    addr_a(1'b1, 2'b10, 12'h008, 1'b0, 3'd2);
    cyc();
    chk("wr08_commit_reg2", regs_a[95:64], 32'hDEADBEEF);
    chk("rd08_wait_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("rd08_final_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("rd08_hrdata", ifa.hrdata, 32'hDEADBEEF);

    // reg3 = 0x11223344, then byte write 0xAB on lane 1 @0x0D
    addr_a(1'b1, 2'b10, 12'h00C, 1'b1, 3'd2);
    cyc();
    ifa.hwdata = 32'h11223344;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    addr_a(1'b1, 2'b10, 12'h00D, 1'b1, 3'd0);
    cyc();
    chk("wr0c_reg3", regs_a[127:96], 32'h11223344);
    ifa.hwdata = 32'h0000AB00;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("byte_final_resp", {31'd0, ifa.hresp}, 32'd0);
    chk("byte_final_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    cyc();
    chk("byte_reg3", regs_a[127:96], 32'h1122AB44);
    chk("byte_reg2_kept", regs_a[95:64], 32'hDEADBEEF);

    // halfword write 0x5566 on upper lanes @0x0E
    addr_a(1'b1, 2'b10, 12'h00E, 1'b1, 3'd1);
    cyc();
    ifa.hwdata = 32'h55660000;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    cyc();
    chk("half_reg3", regs_a[127:96], 32'h5566AB44);

    // Out-of-window write @0x40
    addr_a(1'b1, 2'b10, 12'h040, 1'b1, 3'd2);
    cyc();
    chk("oow_err1_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("oow_err1_resp", {31'd0, ifa.hresp}, 32'd1);
    ifa.hwdata = 32'hFFFFFFFF;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("oow_err2_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("oow_err2_resp", {31'd0, ifa.hresp}, 32'd1);
    cyc();
    chk("oow_idle_resp", {31'd0, ifa.hresp}, 32'd0);
    chk("oow_reg0", regs_a[31:0], 32'd0);
    chk("oow_hrdata_held", ifa.hrdata, 32'hDEADBEEF);

    // Misaligned halfword @0x01, then hsize=3 @0x00 accepted during ERR2
    addr_a(1'b1, 2'b10, 12'h001, 1'b1, 3'd1);
    cyc();
    chk("mis_err1_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("mis_err1_resp", {31'd0, ifa.hresp}, 32'd1);
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("mis_err2_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("mis_err2_resp", {31'd0, ifa.hresp}, 32'd1);
    addr_a(1'b1, 2'b10, 12'h000, 1'b1, 3'd3);
    cyc();
    chk("sz3_err1_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    chk("sz3_err1_resp", {31'd0, ifa.hresp}, 32'd1);
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("sz3_err2_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("sz3_err2_resp", {31'd0, ifa.hresp}, 32'd1);
    cyc();
    chk("sz3_reg0", regs_a[31:0], 32'd0);
    chk("sz3_reg3", regs_a[127:96], 32'h5566AB44);

    // Ignored transfers: IDLE htrans, then NONSEQ with hready=0
    ifa.hwdata = 32'h00000000;
    addr_a(1'b1, 2'b00, 12'h008, 1'b1, 3'd2);
    cyc();
    chk("ign_idle_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("ign_idle_resp", {31'd0, ifa.hresp}, 32'd0);
    addr_a(1'b1, 2'b10, 12'h008, 1'b1, 3'd2);
    nrdy_a = 1'b1;
    cyc();
    chk("ign_nrdy_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("ign_nrdy_resp", {31'd0, ifa.hresp}, 32'd0);
    nrdy_a = 1'b0;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("ign_reg2", regs_a[95:64], 32'hDEADBEEF);
    chk("ign_rdy_after", {31'd0, ifa.hreadyout}, 32'd1);

    // Reset pulse during the wait cycle of a write to 0x00
    addr_a(1'b1, 2'b10, 12'h000, 1'b1, 3'd2);
    cyc();
    chk("rstmid_wait_rdy", {31'd0, ifa.hreadyout}, 32'd0);
    ifa.hwdata = 32'h12345678;
    addr_a(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    hreset = 1'b1;
    #2;
    hreset = 1'b0;
    cyc();
    chk("rstmid_rdy", {31'd0, ifa.hreadyout}, 32'd1);
    chk("rstmid_resp", {31'd0, ifa.hresp}, 32'd0);
    chk("rstmid_hrdata", ifa.hrdata, 32'd0);
    chk("rstmid_regs_or", {31'd0, |regs_a}, 32'd0);
    cyc();
    chk("rstmid_reg0_after", regs_a[31:0], 32'd0);

    // WAIT_STATES=0: write 0xCAFE0001 @0x04 then back-to-back read @0x04
    addr_b(1'b1, 2'b10, 12'h004, 1'b1, 3'd2);
    cyc();
    chk("ws0_wr_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    chk("ws0_wr_resp", {31'd0, ifb.hresp}, 32'd0);
    ifb.hwdata = 32'hCAFE0001;
    addr_b(1'b1, 2'b10, 12'h004, 1'b0, 3'd2);
    cyc();
    chk("ws0_rd_fwd", ifb.hrdata, 32'hCAFE0001);
    chk("ws0_rd_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    chk("ws0_reg1", regs_b[63:32], 32'hCAFE0001);
    ifb.hwdata = 32'h0BADF00D;
    addr_b(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("ws0_hrdata_held", ifb.hrdata, 32'hCAFE0001);
    chk("ws0_reg1_kept", regs_b[63:32], 32'hCAFE0001);

    // WAIT_STATES=0 out-of-window error @0x42
    addr_b(1'b1, 2'b10, 12'h042, 1'b1, 3'd2);
    cyc();
    chk("ws0_err1_rdy", {31'd0, ifb.hreadyout}, 32'd0);
    chk("ws0_err1_resp", {31'd0, ifb.hresp}, 32'd1);
    addr_b(1'b0, 2'b00, 12'h000, 1'b0, 3'd2);
    cyc();
    chk("ws0_err2_rdy", {31'd0, ifb.hreadyout}, 32'd1);
    chk("ws0_err2_resp", {31'd0, ifb.hresp}, 32'd1);
    cyc();
    chk("ws0_idle_resp", {31'd0, ifb.hresp}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
